// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of hazards that forwarding cannot resolve
// (load-use, register-branch source, flag-branch).
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = hazard_pkg::REG_W
) (
  input  logic [REG_W-1:0] fd_regRs,
  input  logic [REG_W-1:0] fd_regRt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic             fd_is_store,
  input  logic             fd_is_br,
  input  logic             fd_is_bcond,
  input  logic             de_memread,
  input  logic             de_regwrite,
  input  logic [REG_W-1:0] de_dstreg,
  input  logic             de_sets_flags,
  input  logic             em_memread,
  input  logic [REG_W-1:0] em_dstreg,
  output logic             hz
);

  localparam logic [REG_W-1:0] ZERO = REG_W'(REG_ZERO);

  logic rs_nz, rt_nz;
  logic ld_use, br_dep, flag_dep;

  // A zero source index can never match a live producer.
  assign rs_nz = (fd_regRs != ZERO);
  assign rt_nz = (fd_regRt != ZERO);

  // Store data (Rt of SW) is forwarded MEM->MEM, so it does not stall.
  assign ld_use = de_memread & de_regwrite &
                  ((fd_uses_rs & rs_nz & (de_dstreg == fd_regRs)) |
                   (fd_uses_rt & rt_nz & (de_dstreg == fd_regRt) & ~fd_is_store));

  assign br_dep = fd_is_br & rs_nz &
                  ((de_regwrite & (de_dstreg == fd_regRs)) |
                   (em_memread  & (em_dstreg == fd_regRs)));

  assign flag_dep = fd_is_bcond & de_sets_flags;

  assign hz = ld_use | br_dep | flag_dep;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: hazard stalls, cache-miss waits, watchdog.
// Optional `HAZARD_PERF_CNT_EN adds stall-cycle and branch-flush performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = hazard_pkg::REG_W,
  parameter int WAIT_CNT_W   = 8,
  parameter int MAX_MEM_WAIT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] fd_regRs,
  input  logic [REG_W-1:0] fd_regRt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic             fd_is_store,
  input  logic             fd_is_br,
  input  logic             fd_is_bcond,
  input  logic             branch_taken,
  input  logic             de_memread,
  input  logic             de_regwrite,
  input  logic [REG_W-1:0] de_dstreg,
  input  logic             de_sets_flags,
  input  logic             em_memread,
  input  logic [REG_W-1:0] em_dstreg,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]      perf_stall_cyc,
  output logic [15:0]      perf_flush_cnt,
`endif
  output logic             mem_timeout
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MAX_MEM_WAIT);

  state_e                state_q, state_d;
  logic                  redir_pend_q, redir_pend_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic                  hz, iw_ctx;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .fd_regRs     (fd_regRs),
    .fd_regRt     (fd_regRt),
    .fd_uses_rs   (fd_uses_rs),
    .fd_uses_rt   (fd_uses_rt),
    .fd_is_store  (fd_is_store),
    .fd_is_br     (fd_is_br),
    .fd_is_bcond  (fd_is_bcond),
    .de_memread   (de_memread),
    .de_regwrite  (de_regwrite),
    .de_dstreg    (de_dstreg),
    .de_sets_flags(de_sets_flags),
    .em_memread   (em_memread),
    .em_dstreg    (em_dstreg),
    .hz           (hz)
  );

  // A data wait that interrupted a fetch wait resumes the fetch wait afterwards.
  assign iw_ctx = (state_q == IWAIT) |
                  ((state_q == DWAIT) & (icache_stall | redir_pend_q));

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    de_en        = 1'b1;
    em_en        = 1'b1;
    mw_en        = 1'b1;
    fd_flush     = 1'b0;
    de_bubble    = 1'b0;

    if (dcache_stall) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
      state_d = DWAIT;
    end else if (iw_ctx) begin
      if (icache_stall) begin
        pc_en    = 1'b0;
        fd_flush = 1'b1;
        state_d  = IWAIT;
      end else begin
        // A pending redirect keeps the final stale fetch out of IF/ID.
        fd_flush     = redir_pend_q;
        redir_pend_d = 1'b0;
        state_d      = RUN;
      end
    end else if (hz) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
      state_d   = RUN;
    end else if (branch_taken) begin
      fd_flush = 1'b1;
      if (icache_stall) begin
        redir_pend_d = 1'b1;
        state_d      = IWAIT;
      end else begin
        state_d = RUN;
      end
    end else if (icache_stall) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
      state_d  = IWAIT;
    end else begin
      state_d = RUN;
    end

    if (!rst_n) begin
      {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (state_d != RUN) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == WAIT_MAX);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q       <= RUN;
      redir_pend_q  <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      redir_pend_q  <= redir_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;
  logic        br_flush;

  assign br_flush = ~dcache_stall & ~iw_ctx & ~hz & branch_taken;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!pc_en && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
    if (br_flush && (perf_flush_q != 16'hFFFF)) perf_flush_d = perf_flush_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a cycle-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fd_regRs, fd_regRt, de_dstreg, em_dstreg;
  logic       fd_uses_rs, fd_uses_rt, fd_is_store, fd_is_br, fd_is_bcond, branch_taken;
  logic       de_memread, de_regwrite, de_sets_flags, em_memread;
  logic       icache_stall, dcache_stall;
  logic       pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_bubble, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fd_regRs     (fd_regRs),
    .fd_regRt     (fd_regRt),
    .fd_uses_rs   (fd_uses_rs),
    .fd_uses_rt   (fd_uses_rt),
    .fd_is_store  (fd_is_store),
    .fd_is_br     (fd_is_br),
    .fd_is_bcond  (fd_is_bcond),
    .branch_taken (branch_taken),
    .de_memread   (de_memread),
    .de_regwrite  (de_regwrite),
    .de_dstreg    (de_dstreg),
    .de_sets_flags(de_sets_flags),
    .em_memread   (em_memread),
    .em_dstreg    (em_dstreg),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .de_en        (de_en),
    .em_en        (em_en),
    .mw_en        (mw_en),
    .fd_flush     (fd_flush),
    .de_bubble    (de_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .mem_timeout  (mem_timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_bubble};
  endfunction

  // Hazard rule straight from the instruction semantics; register 0 never conflicts.
  function automatic bit spec_hz();
    bit lu, bd, fl;
    lu = de_memread && de_regwrite &&
         ((fd_uses_rs && fd_regRs != 0 && de_dstreg == fd_regRs) ||
          (fd_uses_rt && fd_regRt != 0 && de_dstreg == fd_regRt && !fd_is_store));
    bd = fd_is_br && fd_regRs != 0 &&
         ((de_regwrite && de_dstreg == fd_regRs) || (em_memread && em_dstreg == fd_regRs));
    fl = fd_is_bcond && de_sets_flags;
    return lu || bd || fl;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef enum {K_RST, K_DATA, K_FETCH, K_FEXIT, K_HAZ, K_BR, K_BR_FETCH, K_NONE} kind_e;

  int m_wait = 0;
  bit m_tmo = 0, m_after_data = 0, m_fetching = 0, m_redirect = 0;
`ifdef HAZARD_PERF_CNT_EN
  int m_stall = 0, m_flush = 0;
`endif

  initial begin
    kind_e      kind;
    logic [6:0] exp;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n)                 kind = K_RST;
      else if (dcache_stall)      kind = K_DATA;
      else if (m_fetching || (m_after_data && (icache_stall || m_redirect)))
                                  kind = icache_stall ? K_FETCH : K_FEXIT;
      else if (spec_hz())         kind = K_HAZ;
      else if (branch_taken)      kind = icache_stall ? K_BR_FETCH : K_BR;
      else if (icache_stall)      kind = K_FETCH;
      else                        kind = K_NONE;

      case (kind)
        K_DATA:           exp = 7'b00000_00;
        K_FETCH:          exp = 7'b01111_10;
        K_FEXIT:          exp = {5'b11111, m_redirect, 1'b0};
        K_HAZ:            exp = 7'b00111_01;
        K_BR, K_BR_FETCH: exp = 7'b11111_10;
        default:          exp = 7'b11111_00;
      endcase

      check("model_outputs", 32'(outs()), 32'(exp));
      check("model_mem_timeout", 32'(mem_timeout), 32'(m_tmo));
`ifdef HAZARD_PERF_CNT_EN
      check("model_perf_stall", 32'(perf_stall_cyc), 32'(m_stall));
      check("model_perf_flush", 32'(perf_flush_cnt), 32'(m_flush));
`endif

      if (kind == K_RST) begin
        m_wait = 0; m_tmo = 0; m_after_data = 0; m_fetching = 0; m_redirect = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall = 0; m_flush = 0;
`endif
      end else begin
        if (kind inside {K_DATA, K_FETCH, K_BR_FETCH}) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else                                          m_wait = 0;
        if (m_wait == MAX_WAIT) m_tmo = 1;
        m_after_data = (kind == K_DATA);
        m_fetching   = (kind inside {K_FETCH, K_BR_FETCH});
        if (kind == K_BR_FETCH) m_redirect = 1;
        else if (kind == K_FEXIT) m_redirect = 0;
`ifdef HAZARD_PERF_CNT_EN
        if (exp[6] == 1'b0 && m_stall < 65535) m_stall++;
        if (kind inside {K_BR, K_BR_FETCH} && m_flush < 65535) m_flush++;
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #1; endtask

  task automatic clr();
    fd_regRs = 0; fd_regRt = 0; de_dstreg = 0; em_dstreg = 0;
    fd_uses_rs = 0; fd_uses_rt = 0; fd_is_store = 0; fd_is_br = 0; fd_is_bcond = 0;
    branch_taken = 0; de_memread = 0; de_regwrite = 0; de_sets_flags = 0; em_memread = 0;
    icache_stall = 0; dcache_stall = 0;
  endtask

  // LW R3 in EX, ADD R5,R3,R4 in ID
  task automatic set_ld_use();
    de_memread = 1; de_regwrite = 1; de_dstreg = 4'd3;
    fd_uses_rs = 1; fd_regRs = 4'd3; fd_uses_rt = 1; fd_regRt = 4'd4;
  endtask

  initial begin
    int nflush;
    rst_n = 0;
    clr();
    next(); mid();
    check("reset_outputs", 32'(outs()), 32'h7C);
    next(); rst_n = 1; mid();
    check("post_reset_outputs", 32'(outs()), 32'h7C);
    check("post_reset_timeout", 32'(mem_timeout), 32'h0);

    // 1: load-use stalls for one cycle
    next(); set_ld_use(); mid();
    check("ld_use_stall", 32'(outs()), 32'b00111_01);
    next(); clr(); mid();
    check("ld_use_release", 32'(outs()), 32'b11111_00);

    // 2: SW data after LW does not stall; LW R0 does not stall
    next(); de_memread = 1; de_regwrite = 1; de_dstreg = 4'd3;
    fd_is_store = 1; fd_uses_rs = 1; fd_regRs = 4'd2; fd_uses_rt = 1; fd_regRt = 4'd3; mid();
    check("sw_no_stall", 32'(pc_en), 32'h1);
    next(); clr(); de_memread = 1; de_regwrite = 1; de_dstreg = 4'd0;
    fd_uses_rs = 1; fd_regRs = 4'd0; fd_uses_rt = 1; fd_regRt = 4'd0; mid();
    check("r0_no_stall", 32'(outs()), 32'b11111_00);

    // 3: BR R6 with producer in EX (ALU) then in MEM (load)
    next(); clr(); fd_is_br = 1; fd_regRs = 4'd6; de_regwrite = 1; de_dstreg = 4'd6; mid();
    check("br_dep_ex", 32'({pc_en, de_bubble}), 32'b01);
    next(); de_regwrite = 0; de_dstreg = 0; em_memread = 1; em_dstreg = 4'd6; mid();
    check("br_dep_mem", 32'({pc_en, de_bubble}), 32'b01);
    next(); clr(); mid();
    check("br_dep_release", 32'(pc_en), 32'h1);

    // 4: taken branch during a 5-cycle fetch miss
    next(); branch_taken = 1; icache_stall = 1;
    nflush = 0;
    for (int i = 0; i < 7; i++) begin
      mid();
      nflush += int'(fd_flush);
      next();
      branch_taken = 0;
      icache_stall = (i + 1 < 5);
    end
    check("br_icache_flush_cycles", 32'(nflush), 32'd6);
    mid();
    check("br_icache_back_run", 32'(outs()), 32'b11111_00);

    // 5: data miss during load-use, then the load-use stall
    next(); set_ld_use(); dcache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("dcache_freeze", 32'(outs()), 32'h0);
      next();
    end
    dcache_stall = 0; mid();
    check("ld_use_after_dcache", 32'(outs()), 32'b00111_01);
    next(); clr(); mid();
    check("dcache_ld_release", 32'(outs()), 32'b11111_00);

    // data miss interrupting a redirect fetch miss
    next(); branch_taken = 1; icache_stall = 1;
    next(); branch_taken = 0; dcache_stall = 1;
    next(); next(); dcache_stall = 0; mid();
    check("iwait_resume", 32'({pc_en, fd_flush}), 32'b01);
    next(); icache_stall = 0; mid();
    check("iwait_exit_redirect", 32'({pc_en, fd_flush}), 32'b11);
    next(); mid();
    check("iwait_done", 32'(fd_flush), 32'h0);

    // 6: watchdog on a long data miss, then reset mid-wait
    next(); dcache_stall = 1;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      mid();
      if (i == MAX_WAIT - 1) check("timeout_not_yet", 32'(mem_timeout), 32'h0);
      if (i == MAX_WAIT)     check("timeout_asserted", 32'(mem_timeout), 32'h1);
      next();
    end
    dcache_stall = 0; mid();
    check("timeout_sticky", 32'({mem_timeout, pc_en}), 32'b11);
    next(); dcache_stall = 1;
    for (int i = 0; i < 5; i++) next();
    rst_n = 0; mid();
    check("reset_mid_wait_outputs", 32'(outs()), 32'h7C);
    next(); mid();
    check("reset_clears_timeout", 32'(mem_timeout), 32'h0);
    next(); rst_n = 1; dcache_stall = 0; mid();
    check("run_after_reset", 32'({pc_en, mem_timeout}), 32'b10);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_after_reset", 32'(perf_stall_cyc), 32'h0);
`endif
    next(); next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not complete within time limit");
    $fatal(1, "time limit exceeded");
  end

endmodule
